// File: rtl/dcache_sa_ctrl.sv
// Write-back, write-allocate data cache controller, 1- or 2-way set associative with per-set LRU.
// Hits add no stall; a miss stalls the pipeline through an optional write-back, one turnaround cycle and a refill.
module dcache_sa_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 256,
    parameter int SETS      = 32,
    parameter int WAYS      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("dcache_sa_ctrl: WAYS must be 1 or 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_WBACK, S_TURN, S_REFILL} state_t;

    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     idx;
    logic [WORD_W-1:0]    word;
    logic                 unused_addr_bits;
    assign tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx  = p1_addr_i[OFF_W +: IDX_W];
    assign word = p1_addr_i[2 +: WORD_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    logic                 valid_q [WAYS][SETS];
    logic                 dirty_q [WAYS][SETS];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [LINE_BITS-1:0] line_q  [WAYS][SETS];
    logic [SETS-1:0]      lru_q;

    state_t               state_q, state_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;
    logic [IDX_W-1:0]     req_idx_q, req_idx_d;
    logic                 vic_q, vic_d;
    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    logic                 req, hit, hit_way, rd_hit;
    logic [LINE_BITS-1:0] hit_line;
    logic                 vic_way, vic_valid, vic_dirty;
    logic [TAG_W-1:0]     vic_tag;
    logic [LINE_BITS-1:0] vic_line;
    logic                 hit_upd, wr_merge, wb_done, fill_we;

    always_comb begin
        hit      = 1'b0;
        hit_way  = 1'b0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit      = 1'b1;
                hit_way  = 1'(w);
                hit_line = line_q[w][idx];
            end
        end
    end

    // Descending scan so that the lowest-numbered invalid way wins over the LRU way.
    always_comb begin
        vic_way = (WAYS == 2) ? lru_q[idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) vic_way = 1'(w);
        end
        vic_valid = 1'b0;
        vic_dirty = 1'b0;
        vic_tag   = '0;
        vic_line  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (1'(w) == vic_way) begin
                vic_valid = valid_q[w][idx];
                vic_dirty = dirty_q[w][idx];
                vic_tag   = tag_q[w][idx];
                vic_line  = line_q[w][idx];
            end
        end
    end

    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign rd_hit     = p1_MemRead_i & ~p1_MemWrite_i & hit & (state_q == S_IDLE);
    assign p1_stall_o = req & ~((state_q == S_IDLE) & hit);
    assign p1_data_o  = rd_hit ? hit_line[{word, 5'b0} +: 32] : 32'h0;

    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        vic_d        = vic_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        hit_upd      = 1'b0;
        wr_merge     = 1'b0;
        wb_done      = 1'b0;
        fill_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    hit_upd  = 1'b1;
                    wr_merge = p1_MemWrite_i;
                end else if (req) begin
                    req_tag_d    = tag;
                    req_idx_d    = idx;
                    vic_d        = vic_way;
                    mem_enable_d = 1'b1;
                    if (vic_valid && vic_dirty) begin
                        state_d     = S_WBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {vic_tag, idx, {OFF_W{1'b0}}};
                        mem_data_d  = vic_line;
                    end else begin
                        state_d     = S_REFILL;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {tag, idx, {OFF_W{1'b0}}};
                    end
                end
            end
            S_WBACK: begin
                if (mem_ack_i) begin
                    state_d      = S_TURN;
                    wb_done      = 1'b1;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_data_d   = '0;
                end
            end
            S_TURN: begin
                state_d      = S_REFILL;
                mem_enable_d = 1'b1;
                mem_addr_d   = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            end
            default: begin
                if (mem_ack_i) begin
                    state_d      = S_IDLE;
                    fill_we      = 1'b1;
                    mem_enable_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            vic_q        <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            vic_q        <= vic_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
            lru_q <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (wr_merge && 1'(w) == hit_way) dirty_q[w][idx] <= 1'b1;
                if (wb_done && 1'(w) == vic_q) dirty_q[w][req_idx_q] <= 1'b0;
                if (fill_we && 1'(w) == vic_q) begin
                    valid_q[w][req_idx_q] <= 1'b1;
                    dirty_q[w][req_idx_q] <= 1'b0;
                end
            end
            if (WAYS == 2) begin
                if (hit_upd) lru_q[idx] <= ~hit_way;
                else if (fill_we) lru_q[req_idx_q] <= ~vic_q;
            end
        end
    end

    // Line and tag storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_merge && 1'(w) == hit_way) line_q[w][idx][{word, 5'b0} +: 32] <= p1_data_i;
            if (fill_we && 1'(w) == vic_q) begin
                line_q[w][req_idx_q] <= mem_data_i;
                tag_q[w][req_idx_q]  <= req_tag_q;
            end
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// Bench for dcache_sa_ctrl: one 2-way and one direct-mapped instance, each backed by a behavioural memory.
// Expected memory transactions and load data are queued when stimulus is driven and checked when the DUT produces them.
module tb_dcache_sa_ctrl;
    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] data;
    } txn_t;

    logic         clk;
    logic         rst_n;
    logic [31:0]  p1_addr  [2];
    logic [31:0]  p1_wdat  [2];
    logic         p1_rd    [2];
    logic         p1_wr    [2];
    logic [31:0]  p1_rdat  [2];
    logic         stall    [2];
    logic [255:0] mrdat    [2];
    logic         mack     [2];
    logic         spur     [2];
    logic [255:0] mwdat    [2];
    logic [31:0]  maddr    [2];
    logic         men      [2];
    logic         mwr      [2];
    int           dly      [2];

    int total = 0;
    int bad   = 0;
    txn_t        exp_mem [$];
    logic [31:0] exp_rd  [$];
    logic [255:0] mem_model [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dcache_sa_ctrl #(.ADDR_W(32), .LINE_BITS(256), .SETS(32), .WAYS(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n),
        .p1_addr_i(p1_addr[0]), .p1_data_i(p1_wdat[0]),
        .p1_MemRead_i(p1_rd[0]), .p1_MemWrite_i(p1_wr[0]),
        .p1_data_o(p1_rdat[0]), .p1_stall_o(stall[0]),
        .mem_data_i(mrdat[0]), .mem_ack_i(mack[0] | spur[0]),
        .mem_data_o(mwdat[0]), .mem_addr_o(maddr[0]),
        .mem_enable_o(men[0]), .mem_write_o(mwr[0])
    );

    dcache_sa_ctrl #(.ADDR_W(32), .LINE_BITS(256), .SETS(32), .WAYS(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .p1_addr_i(p1_addr[1]), .p1_data_i(p1_wdat[1]),
        .p1_MemRead_i(p1_rd[1]), .p1_MemWrite_i(p1_wr[1]),
        .p1_data_o(p1_rdat[1]), .p1_stall_o(stall[1]),
        .mem_data_i(mrdat[1]), .mem_ack_i(mack[1] | spur[1]),
        .mem_data_o(mwdat[1]), .mem_addr_o(maddr[1]),
        .mem_enable_o(men[1]), .mem_write_o(mwr[1])
    );

    function automatic logic [255:0] mem_rd(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (32'(k) << 28) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] l, input int w);
        return l[w*32 +: 32];
    endfunction

    function automatic logic [255:0] with_word(input logic [255:0] l, input int w, input logic [31:0] v);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = v;
        return r;
    endfunction

    // Memory responders: check each request against the expected queue, then ack after dly cycles.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        initial begin
            int turn;
            txn_t e;
            logic [31:0] a;
            logic wrf;
            logic [255:0] wd;
            turn = 0;
            mack[g] = 1'b0;
            mrdat[g] = '0;
            forever begin
                @(negedge clk);
                mack[g] = 1'b0;
                if (!rst_n) begin
                    turn = 0;
                    continue;
                end
                if (turn == 1) begin
                    total++;
                    if (men[g] !== 1'b0) begin
                        bad++;
                        $display("FAIL turn_enable_low dut=%0d got=%b want=0", g, men[g]);
                    end
                    turn = 2;
                    continue;
                end
                if (turn == 2) begin
                    total++;
                    if (men[g] !== 1'b1) begin
                        bad++;
                        $display("FAIL turn_single_cycle dut=%0d got=%b want=1", g, men[g]);
                    end
                    turn = 0;
                end
                if (men[g] === 1'b1) begin
                    a   = maddr[g];
                    wrf = mwr[g];
                    wd  = mwdat[g];
                    total++;
                    if (exp_mem.size() == 0) begin
                        bad++;
                        $display("FAIL mem_txn dut=%0d unexpected wr=%b addr=%h", g, wrf, a);
                    end else begin
                        e = exp_mem.pop_front();
                        if (e.dut != g || e.wr !== wrf || e.addr !== a || (wrf && e.data !== wd)) begin
                            bad++;
                            $display("FAIL mem_txn dut=%0d got wr=%b addr=%h data=%h want dut=%0d wr=%b addr=%h data=%h",
                                     g, wrf, a, wd, e.dut, e.wr, e.addr, e.data);
                        end
                    end
                    for (int k = 0; k < dly[g]; k++) begin
                        @(negedge clk);
                        if (!rst_n) break;
                    end
                    if (rst_n) begin
                        if (wrf) begin
                            mem_model[a] = wd;
                            turn = 1;
                        end else begin
                            mrdat[g] = mem_rd(a);
                        end
                        mack[g] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_data, input int exp_stall,
                          input string nm);
        int cnt;
        logic [31:0] e;
        @(negedge clk);
        p1_addr[d] = a;
        p1_rd[d]   = rd;
        p1_wr[d]   = wr;
        p1_wdat[d] = wd;
        if (rd && !wr) exp_rd.push_back(exp_data);
        cnt = 0;
        forever begin
            #1;
            if (!stall[d]) break;
            cnt++;
            if (cnt > 500) begin
                total++;
                bad++;
                $display("FAIL %s_timeout dut=%0d stall still high after %0d cycles", nm, d, cnt);
                break;
            end
            @(negedge clk);
        end
        total++;
        if (cnt != exp_stall) begin
            bad++;
            $display("FAIL %s_stall dut=%0d got=%0d want=%0d", nm, d, cnt, exp_stall);
        end
        total++;
        if (rd && !wr) begin
            e = exp_rd.pop_front();
            if (p1_rdat[d] !== e) begin
                bad++;
                $display("FAIL %s_data dut=%0d got=%h want=%h", nm, d, p1_rdat[d], e);
            end
        end else if (p1_rdat[d] !== 32'h0) begin
            bad++;
            $display("FAIL %s_data_zero dut=%0d got=%h want=0", nm, d, p1_rdat[d]);
        end
        @(negedge clk);
        p1_rd[d] = 1'b0;
        p1_wr[d] = 1'b0;
    endtask

    task automatic push_txn(input int d, input logic wr, input logic [31:0] a, input logic [255:0] dat);
        txn_t t;
        t.dut = d; t.wr = wr; t.addr = a; t.data = dat;
        exp_mem.push_back(t);
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            p1_rd[d] = 1'b1;
            p1_addr[d] = 32'h40;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (stall[d] !== 1'b1) begin bad++; $display("FAIL rst_stall_miss dut=%0d got=%b want=1", d, stall[d]); end
            total++;
            if (p1_rdat[d] !== 32'h0) begin bad++; $display("FAIL rst_p1_data dut=%0d got=%h want=0", d, p1_rdat[d]); end
            total++;
            if (men[d] !== 1'b0 || mwr[d] !== 1'b0) begin
                bad++; $display("FAIL rst_mem_ctl dut=%0d got en=%b wr=%b want 0 0", d, men[d], mwr[d]);
            end
            total++;
            if (maddr[d] !== 32'h0 || mwdat[d] !== 256'h0) begin
                bad++; $display("FAIL rst_mem_bus dut=%0d got addr=%h data=%h want 0", d, maddr[d], mwdat[d]);
            end
            p1_rd[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (stall[d] !== 1'b0) begin bad++; $display("FAIL rst_stall_idle dut=%0d got=%b want=0", d, stall[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_load;
        dly[0] = 10;
        push_txn(0, 1'b0, 32'h40, '0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, word_of(mem_rd(32'h40), 0), 12, "cold_load");
    endtask

    task automatic test_store_hit;
        access(0, 1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h0, 0, "store_hit");
        access(0, 1'b1, 1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 0, "load_after_store");
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, word_of(mem_rd(32'h40), 0), 0, "load_neighbour");
    endtask

    task automatic test_two_way_evict;
        dly[0] = 3;
        push_txn(0, 1'b0, 32'h440, '0);
        access(0, 1'b1, 1'b0, 32'h440, 32'h0, word_of(mem_rd(32'h440), 0), 5, "fill_way1");
        push_txn(0, 1'b1, 32'h40, with_word(mem_rd(32'h40), 1, 32'hDEADBEEF));
        push_txn(0, 1'b0, 32'h840, '0);
        access(0, 1'b1, 1'b0, 32'h84C, 32'h0, word_of(mem_rd(32'h840), 3), 10, "evict_dirty");
        access(0, 1'b1, 1'b0, 32'h440, 32'h0, word_of(mem_rd(32'h440), 0), 0, "keep_way1");
        push_txn(0, 1'b0, 32'hC40, '0);
        access(0, 1'b1, 1'b0, 32'hC5C, 32'h0, word_of(mem_rd(32'hC40), 7), 5, "evict_clean_lru");
        access(0, 1'b1, 1'b0, 32'h440, 32'h0, word_of(mem_rd(32'h440), 0), 0, "lru_kept_mru");
    endtask

    task automatic test_one_way;
        dly[1] = 2;
        push_txn(1, 1'b0, 32'h40, '0);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, word_of(mem_rd(32'h40), 0), 4, "dm_fill");
        push_txn(1, 1'b0, 32'h440, '0);
        access(1, 1'b1, 1'b0, 32'h440, 32'h0, word_of(mem_rd(32'h440), 0), 4, "dm_conflict");
        push_txn(1, 1'b0, 32'h40, '0);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, word_of(mem_rd(32'h40), 0), 4, "dm_reload");
        access(1, 1'b0, 1'b1, 32'h48, 32'hCAFEF00D, 32'h0, 0, "dm_store");
        push_txn(1, 1'b1, 32'h40, with_word(mem_rd(32'h40), 2, 32'hCAFEF00D));
        push_txn(1, 1'b0, 32'h440, '0);
        access(1, 1'b1, 1'b0, 32'h448, 32'h0, word_of(mem_rd(32'h440), 2), 8, "dm_evict_dirty");
    endtask

    task automatic test_reset_mid_refill;
        dly[0] = 20;
        push_txn(0, 1'b0, 32'h1040, '0);
        @(negedge clk);
        p1_addr[0] = 32'h1040;
        p1_rd[0]   = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (men[0] !== 1'b1 || mwr[0] !== 1'b0 || maddr[0] !== 32'h1040) begin
            bad++; $display("FAIL mid_refill dut=0 got en=%b wr=%b addr=%h want 1 0 00001040", men[0], mwr[0], maddr[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (men[0] !== 1'b0 || maddr[0] !== 32'h0 || mwr[0] !== 1'b0) begin
            bad++; $display("FAIL async_rst_mem dut=0 got en=%b wr=%b addr=%h want 0 0 0", men[0], mwr[0], maddr[0]);
        end
        total++;
        if (stall[0] !== 1'b1) begin bad++; $display("FAIL async_rst_stall dut=0 got=%b want=1", stall[0]); end
        @(negedge clk);
        p1_rd[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dly[0] = 1;
        push_txn(0, 1'b0, 32'h440, '0);
        access(0, 1'b1, 1'b0, 32'h440, 32'h0, word_of(mem_rd(32'h440), 0), 3, "post_rst_miss");
        push_txn(0, 1'b0, 32'h40, '0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, word_of(mem_rd(32'h40), 0), 3, "post_rst_refill");
    endtask

    task automatic test_ack_edge;
        dly[0] = 0;
        @(negedge clk);
        spur[0] = 1'b1;
        @(negedge clk);
        spur[0] = 1'b0;
        #1;
        total++;
        if (men[0] !== 1'b0 || stall[0] !== 1'b0) begin
            bad++; $display("FAIL idle_ack dut=0 got en=%b stall=%b want 0 0", men[0], stall[0]);
        end
        access(0, 1'b1, 1'b0, 32'h440, 32'h0, word_of(mem_rd(32'h440), 0), 0, "hit_after_spur");
        push_txn(0, 1'b0, 32'h2040, '0);
        access(0, 1'b1, 1'b0, 32'h2044, 32'h0, word_of(mem_rd(32'h2040), 1), 2, "zero_delay_ack");
        push_txn(0, 1'b0, 32'h3040, '0);
        access(0, 1'b1, 1'b1, 32'h3048, 32'h12345678, 32'h0, 2, "write_miss_rdwr");
        access(0, 1'b1, 1'b0, 32'h3048, 32'h0, 32'h12345678, 0, "write_alloc_merge");
        access(0, 1'b1, 1'b0, 32'h304C, 32'h0, word_of(mem_rd(32'h3040), 3), 0, "write_alloc_rest");
        access(0, 1'b1, 1'b0, 32'h2044, 32'h0, word_of(mem_rd(32'h2040), 1), 0, "other_way_kept");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            p1_addr[d] = '0;
            p1_wdat[d] = '0;
            p1_rd[d]   = 1'b0;
            p1_wr[d]   = 1'b0;
            spur[d]    = 1'b0;
            dly[d]     = 0;
        end
        test_reset;
        test_cold_load;
        test_store_hit;
        test_two_way_evict;
        test_one_way;
        test_reset_mid_refill;
        test_ack_edge;
        repeat (3) @(negedge clk);
        total++;
        if (exp_mem.size() != 0) begin
            bad++; $display("FAIL mem_queue_drained got=%0d want=0", exp_mem.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
